// File: rtl/source_operand_dispatch_if.sv
// Operand dispatch bus: register-read side offer plus per-unit operand channels.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface source_operand_dispatch_if #(
   parameter int WORD_SIZE = `WORD_SIZE,
   parameter int NUM_UNITS = 3,
   parameter int SEL_W     = 2
);
   logic                           in_valid;
   logic                           in_ready;
   logic [SEL_W-1:0]               in_sel;
   logic [WORD_SIZE-1:0]           in_data;
   logic [NUM_UNITS-1:0]           out_valid;
   logic [NUM_UNITS-1:0]           out_ready;
   logic [NUM_UNITS*WORD_SIZE-1:0] out_data;
   logic                           illegal_sel;

   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data, illegal_sel
   );

   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data, illegal_sel
   );
endinterface

// File: rtl/source_operand_dispatch.sv
// Routes source-operand words into per-unit FIFOs with independent valid/ready drains.
// Optional DISPATCH_STATS_EN adds saturating accept/drop counters.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module sod_channel #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         rdy,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic         full,
   output logic [W-1:0] dout
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][W-1:0] mem;
   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic [CW-1:0]           count;
   logic                    pop;

   assign valid = (count != '0);
   assign full  = (count == CW'(DEPTH));
   assign dout  = mem[rd_ptr];
   assign pop   = valid && rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         // storage is left as-is; count==0 already masks it
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module source_operand_dispatch #(
   parameter int WORD_SIZE = `WORD_SIZE,
   parameter int NUM_UNITS = 3,
   parameter int SEL_W     = 2,
   parameter int DEPTH     = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   source_operand_dispatch_if.slave     bus
`ifdef DISPATCH_STATS_EN
   ,
   output logic [15:0]                  accept_count,
   output logic [15:0]                  drop_count
`endif
);
   logic [NUM_UNITS-1:0] full;
   logic [NUM_UNITS-1:0] push;
   logic                 sel_illegal;
   logic                 sel_full;
   logic                 accept;

   assign sel_illegal = int'(bus.in_sel) >= NUM_UNITS;

   // full[] is looked up by compare so out-of-range selects never index past the vector
   always_comb begin
      sel_full = 1'b0;
      for (int k = 0; k < NUM_UNITS; k++)
         if (bus.in_sel == SEL_W'(k)) sel_full = full[k];
   end

   assign bus.in_ready = !flush && (sel_illegal || !sel_full);
   assign accept       = bus.in_valid && bus.in_ready;

   for (genvar k = 0; k < NUM_UNITS; k++) begin : g_ch
      assign push[k] = accept && (bus.in_sel == SEL_W'(k));

      sod_channel #(.W(WORD_SIZE), .DEPTH(DEPTH)) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .flush (flush),
         .push  (push[k]),
         .rdy   (bus.out_ready[k]),
         .din   (bus.in_data),
         .valid (bus.out_valid[k]),
         .full  (full[k]),
         .dout  (bus.out_data[k*WORD_SIZE +: WORD_SIZE])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     bus.illegal_sel <= 1'b0;
      else if (flush) bus.illegal_sel <= 1'b0;
      else            bus.illegal_sel <= accept && sel_illegal;
   end

`ifdef DISPATCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accept_count <= '0;
         drop_count   <= '0;
      end else if (flush) begin
         accept_count <= '0;
         drop_count   <= '0;
      end else if (accept) begin
         if (sel_illegal) begin
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
         end else begin
            if (accept_count != 16'hFFFF) accept_count <= accept_count + 1'b1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_source_operand_dispatch.sv
// Directed-vector bench for source_operand_dispatch (default 3 units, DEPTH 2, 32-bit words).
module tb_source_operand_dispatch;
   localparam int W = 32;
   localparam int NU = 3;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   source_operand_dispatch_if #(.WORD_SIZE(W), .NUM_UNITS(NU), .SEL_W(SW)) bus ();

`ifdef DISPATCH_STATS_EN
   logic [15:0] accept_count, drop_count;
`endif

   source_operand_dispatch #(.WORD_SIZE(W), .NUM_UNITS(NU), .SEL_W(SW), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
`ifdef DISPATCH_STATS_EN
      ,
      .accept_count (accept_count),
      .drop_count   (drop_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_sel    = '0;
      bus.in_data   = '0;
      bus.out_ready = '0;
      #2;
      chk("rst_out_valid", bus.out_valid, 3'b000);
      chk("rst_out_data", bus.out_data, 96'h0);
      chk("rst_illegal", bus.illegal_sel, 1'b0);
      #10 rst_n = 1'b1;
      step();
      chk("post_rst_in_ready", bus.in_ready, 1'b1);

      // single word to ADD channel, held while consumer stalls
      bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 32'hA5A5_0001;
      step();
      bus.in_valid = 1'b0;
      chk("t1_valid", bus.out_valid, 3'b001);
      chk("t1_data", bus.out_data[31:0], 32'hA5A5_0001);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t1_hold_valid", bus.out_valid, 3'b001);
         chk("t1_hold_data", bus.out_data[31:0], 32'hA5A5_0001);
      end
      bus.out_ready = 3'b001;
      step();
      chk("t1_popped", bus.out_valid, 3'b000);
      bus.out_ready = 3'b000;

      // fill MULT channel, back-pressure, then drain in order
      bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 32'h11;
      #1 chk("t2_rdy0", bus.in_ready, 1'b1);
      step();
      bus.in_data = 32'h22;
      #1 chk("t2_rdy1", bus.in_ready, 1'b1);
      step();
      bus.in_data = 32'h33;
      #1 chk("t2_full_rdy", bus.in_ready, 1'b0);
      step();
      chk("t2_valid", bus.out_valid, 3'b010);
      chk("t2_head1", bus.out_data[63:32], 32'h11);
      bus.out_ready = 3'b010;
      #1 chk("t2_full_pop_rdy", bus.in_ready, 1'b0);
      step();
      chk("t2_head2", bus.out_data[63:32], 32'h22);
      chk("t2_rdy_after_pop", bus.in_ready, 1'b1);
      step();
      bus.in_valid = 1'b0;
      chk("t2_head3", bus.out_data[63:32], 32'h33);
      chk("t2_valid3", bus.out_valid, 3'b010);
      step();
      chk("t2_drained", bus.out_valid, 3'b000);
      bus.out_ready = 3'b000;

      // streaming to MULADD with consumer always ready
      bus.out_ready = 3'b100;
      bus.in_sel = 2'd2;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.in_data = 32'h300 + i;
         #1 chk("t3_rdy", bus.in_ready, 1'b1);
         step();
         chk("t3_valid", bus.out_valid, 3'b100);
         chk("t3_data", bus.out_data[95:64], 32'h300 + i);
      end
      bus.in_valid = 1'b0;
      step();
      chk("t3_drained", bus.out_valid, 3'b000);
      bus.out_ready = 3'b000;

      // illegal select: accepted, dropped, one-cycle pulse
      bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.in_data = 32'hBAD;
      #1 chk("t4_rdy", bus.in_ready, 1'b1);
      step();
      bus.in_valid = 1'b0;
      chk("t4_pulse", bus.illegal_sel, 1'b1);
      chk("t4_no_valid", bus.out_valid, 3'b000);
`ifdef DISPATCH_STATS_EN
      chk("t4_drop", drop_count, 16'd1);
      chk("t4_accept", accept_count, 16'd10);
`endif
      step();
      chk("t4_pulse_end", bus.illegal_sel, 1'b0);
      bus.in_valid = 1'b1;
      step();
      chk("t4_b2b_a", bus.illegal_sel, 1'b1);
      step();
      bus.in_valid = 1'b0;
      chk("t4_b2b_b", bus.illegal_sel, 1'b1);
      step();
      chk("t4_b2b_end", bus.illegal_sel, 1'b0);

      // fill channels 0 and 1, then flush with a word offered
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_sel = SW'(i / 2);
         bus.in_data = 32'hC0 + i;
         step();
      end
      chk("t5_filled", bus.out_valid, 3'b011);
      flush = 1'b1; bus.in_sel = 2'd2; bus.in_data = 32'hDEAD;
      #1 chk("t5_flush_rdy", bus.in_ready, 1'b0);
      step();
      flush = 1'b0; bus.in_valid = 1'b0;
      chk("t5_flushed", bus.out_valid, 3'b000);
      chk("t5_illegal", bus.illegal_sel, 1'b0);
`ifdef DISPATCH_STATS_EN
      chk("t5_acc_clr", accept_count, 16'd0);
      chk("t5_drop_clr", drop_count, 16'd0);
`endif
      step();
      chk("t5_not_stored", bus.out_valid, 3'b000);

      // async reset mid-cycle with ADD channel full
      bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 32'hF0;
      step();
      bus.in_data = 32'hF1;
      step();
      bus.in_valid = 1'b0;
      chk("t6_full", bus.out_data[31:0], 32'hF0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", bus.out_valid, 3'b000);
      chk("t6_rst_data", bus.out_data, 96'h0);
      step();
      #2 rst_n = 1'b1;
      bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 32'hE0;
      #1 chk("t6_rdy", bus.in_ready, 1'b1);
      step();
      bus.in_valid = 1'b0;
      chk("t6_lat_valid", bus.out_valid, 3'b001);
      chk("t6_lat_data", bus.out_data[31:0], 32'hE0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
